noc_edge_bridge: RTL and testbench

Host-side bridge at the mesh boundary. It buffers 32-bit spike flits written by the host and injects them into an edge port of a `node`; it also drains flits leaving the mesh through that port into a read buffer for the host. It owns both directions of one `node` port pair (din/vin/rout and dout/vout/rin) and keeps wrapping transfer counters plus a sticky overflow flag.

---
 rtl/noc_pkg.sv | 5 +
 rtl/sync_fifo.sv | 56 +++++
 rtl/noc_edge_bridge.sv | 74 +++++++
 tb/tb_noc_edge_bridge.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit width and flit type, common to router, NI and edge bridge.
package noc_pkg;
  localparam int unsigned FLIT_W = 32;
  typedef logic [FLIT_W-1:0] flit_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrapping (log2(DEPTH)+1)-bit pointers, registered status flags
// and show-ahead read data.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wp, rp, wp_n, rp_n;
  logic             push_ok, pop_ok;

  // Flags are the pre-edge state, so a full FIFO rejects a push even when popped that cycle.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wp_n = wp + {{AW{1'b0}}, push_ok};
    rp_n = rp + {{AW{1'b0}}, pop_ok};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp    <= '0;
      rp    <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else if (clr) begin
      wp    <= '0;
      rp    <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      wp    <= wp_n;
      rp    <= rp_n;
      full  <= (wp_n[AW] != rp_n[AW]) && (wp_n[AW-1:0] == rp_n[AW-1:0]);
      empty <= (wp_n == rp_n);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clr) mem[wp[AW-1:0]] <= din;
  end

  assign dout = mem[rp[AW-1:0]];
endmodule

// File: rtl/noc_edge_bridge.sv
// Host <-> mesh edge bridge: egress/ingress FIFOs on one node port pair, transfer
// counters and a sticky egress overflow flag.
module noc_edge_bridge
  import noc_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_wr_en,
  input  logic [FLIT_W-1:0] host_wr_data,
  output logic              host_full,
  input  logic              host_rd_en,
  output logic [FLIT_W-1:0] host_rd_data,
  output logic              host_empty,
  input  logic              flush,
  output logic [FLIT_W-1:0] noc_dout,
  output logic              noc_vout,
  input  logic              noc_rin,
  input  logic [FLIT_W-1:0] noc_din,
  input  logic              noc_vin,
  output logic              noc_rout,
  output logic [CNT_W-1:0]  tx_count,
  output logic [CNT_W-1:0]  rx_count,
  output logic              overflow
);
  logic eg_empty, in_full;
  logic tx_hs, rx_hs;

  sync_fifo #(.WIDTH(FLIT_W), .DEPTH(DEPTH)) u_egress (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .push  (host_wr_en),
    .pop   (noc_rin),
    .din   (host_wr_data),
    .dout  (noc_dout),
    .full  (host_full),
    .empty (eg_empty)
  );

  sync_fifo #(.WIDTH(FLIT_W), .DEPTH(DEPTH)) u_ingress (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .push  (noc_vin),
    .pop   (host_rd_en),
    .din   (noc_din),
    .dout  (host_rd_data),
    .full  (in_full),
    .empty (host_empty)
  );

  assign noc_vout = !eg_empty;
  assign noc_rout = !in_full;

  // Handshakes coinciding with flush are discarded, so they are not counted either.
  assign tx_hs = noc_vout && noc_rin && !flush;
  assign rx_hs = noc_vin && noc_rout && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_count <= '0;
      rx_count <= '0;
      overflow <= 1'b0;
    end else begin
      if (tx_hs) tx_count <= tx_count + CNT_W'(1);
      if (rx_hs) rx_count <= rx_count + CNT_W'(1);
      if (flush)                         overflow <= 1'b0;
      else if (host_wr_en && host_full)  overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_noc_edge_bridge.sv
// Directed self-checking bench for noc_edge_bridge (DEPTH = 8, CNT_W = 16).
module tb_noc_edge_bridge;
  logic        clk = 1'b0;
  logic        rst;
  logic        host_wr_en, host_rd_en, flush;
  logic [31:0] host_wr_data, host_rd_data;
  logic        host_full, host_empty;
  logic [31:0] noc_dout, noc_din;
  logic        noc_vout, noc_rin, noc_vin, noc_rout;
  logic [15:0] tx_count, rx_count;
  logic        overflow;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned tx_exp = 0;
  int unsigned rx_exp = 0;

  always #5 clk = ~clk;

  noc_edge_bridge #(.DEPTH(8), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .host_wr_en   (host_wr_en),
    .host_wr_data (host_wr_data),
    .host_full    (host_full),
    .host_rd_en   (host_rd_en),
    .host_rd_data (host_rd_data),
    .host_empty   (host_empty),
    .flush        (flush),
    .noc_dout     (noc_dout),
    .noc_vout     (noc_vout),
    .noc_rin      (noc_rin),
    .noc_din      (noc_din),
    .noc_vin      (noc_vin),
    .noc_rout     (noc_rout),
    .tx_count     (tx_count),
    .rx_count     (rx_count),
    .overflow     (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; host_wr_en = 1'b0; host_rd_en = 1'b0; flush = 1'b0;
    host_wr_data = '0; noc_din = '0; noc_vin = 1'b0; noc_rin = 1'b1;
    #12;
    chk("rst_full",  {31'd0, host_full},  32'd0);
    chk("rst_empty", {31'd0, host_empty}, 32'd1);
    chk("rst_vout",  {31'd0, noc_vout},   32'd0);
    chk("rst_rout",  {31'd0, noc_rout},   32'd1);
    chk("rst_tx",    {16'd0, tx_count},   32'd0);
    chk("rst_rx",    {16'd0, rx_count},   32'd0);
    chk("rst_ovf",   {31'd0, overflow},   32'd0);
    rst = 1'b1;
    tick();

    // Egress pass-through, one flit per cycle from cycle N+1
    for (int i = 1; i <= 3; i++) begin
      host_wr_en = 1'b1; host_wr_data = 32'hA5A5_0000 + i;
      tick();
      chk("t1_vout", {31'd0, noc_vout}, 32'd1);
      chk("t1_dout", noc_dout, 32'hA5A5_0000 + i);
    end
    host_wr_en = 1'b0;
    tick();
    tx_exp += 3;
    chk("t1_vout_idle", {31'd0, noc_vout}, 32'd0);
    chk("t1_tx", {16'd0, tx_count}, tx_exp);

    // Back-pressure, full and overflow
    noc_rin = 1'b0;
    for (int i = 0; i < 9; i++) begin
      host_wr_en = 1'b1; host_wr_data = 32'hB000_0000 + i;
      tick();
      if (i == 6) chk("t2_full7", {31'd0, host_full}, 32'd0);
      if (i == 7) begin
        chk("t2_full8", {31'd0, host_full}, 32'd1);
        chk("t2_ovf8",  {31'd0, overflow},  32'd0);
      end
      if (i < 7) chk("t2_hold", noc_dout, 32'hB000_0000);
    end
    chk("t2_ovf9", {31'd0, overflow}, 32'd1);
    host_wr_en = 1'b0; noc_rin = 1'b1;
    for (int j = 0; j < 8; j++) begin
      chk("t2_drain", noc_dout, 32'hB000_0000 + j);
      tick();
    end
    tx_exp += 8;
    chk("t2_vout_end", {31'd0, noc_vout}, 32'd0);
    chk("t2_tx", {16'd0, tx_count}, tx_exp);

    // Flush with buffered flits in both directions and overflow set
    noc_rin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      host_wr_en = 1'b1; host_wr_data = 32'hC000_0000 + i;
      noc_vin = (i < 2); noc_din = 32'hD000_0000 + i;
      tick();
    end
    host_wr_en = 1'b0; noc_vin = 1'b0;
    rx_exp += 2;
    chk("t5_vout_pre",  {31'd0, noc_vout},   32'd1);
    chk("t5_empty_pre", {31'd0, host_empty}, 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5_empty", {31'd0, host_empty}, 32'd1);
    chk("t5_vout",  {31'd0, noc_vout},   32'd0);
    chk("t5_ovf",   {31'd0, overflow},   32'd0);
    chk("t5_tx",    {16'd0, tx_count},   tx_exp);
    chk("t5_rx",    {16'd0, rx_count},   rx_exp);

    // Ingress fill to full, then host drain
    for (int i = 0; i < 9; i++) begin
      noc_vin = 1'b1; noc_din = (i < 8) ? 32'h100 + i : 32'h1FF;
      chk("t3_rout", {31'd0, noc_rout}, (i < 8) ? 32'd1 : 32'd0);
      tick();
    end
    noc_vin = 1'b0;
    rx_exp += 8;
    chk("t3_rout_full", {31'd0, noc_rout}, 32'd0);
    chk("t3_rx", {16'd0, rx_count}, rx_exp);
    for (int j = 0; j < 8; j++) begin
      chk("t3_rd", host_rd_data, 32'h100 + j);
      host_rd_en = 1'b1;
      tick();
    end
    chk("t3_empty", {31'd0, host_empty}, 32'd1);
    tick();
    host_rd_en = 1'b0;
    chk("t3_rd_empty", {31'd0, host_empty}, 32'd1);
    chk("t3_rx_end", {16'd0, rx_count}, rx_exp);

    // Simultaneous push/pop at occupancy 4
    for (int i = 0; i < 4; i++) begin
      noc_vin = 1'b1; noc_din = 32'h200 + i;
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      noc_vin = 1'b1; noc_din = 32'h204 + i; host_rd_en = 1'b1;
      chk("t4_rd",   host_rd_data, 32'h200 + i);
      chk("t4_rout", {31'd0, noc_rout}, 32'd1);
      tick();
    end
    noc_vin = 1'b0;
    for (int j = 0; j < 4; j++) begin
      chk("t4_tail", host_rd_data, 32'h20A + j);
      tick();
    end
    host_rd_en = 1'b0;
    rx_exp += 14;
    chk("t4_empty", {31'd0, host_empty}, 32'd1);
    chk("t4_rx", {16'd0, rx_count}, rx_exp);

    // tx_count wrap: bring to 0xFFFF, then one more handshake
    noc_rin = 1'b1;
    for (int i = 0; i < 65535 - int'(tx_exp); i++) begin
      host_wr_en = 1'b1; host_wr_data = i;
      tick();
    end
    host_wr_en = 1'b0;
    tick();
    chk("t6_tx_max", {16'd0, tx_count}, 32'h0000_FFFF);
    host_wr_en = 1'b1; host_wr_data = 32'hE000_0000;
    tick();
    host_wr_en = 1'b0;
    tick();
    chk("t6_tx_wrap", {16'd0, tx_count}, 32'd0);

    // Asynchronous reset mid-transfer drops everything
    noc_rin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      host_wr_en = 1'b1; host_wr_data = 32'hF000_0000 + i;
      noc_vin = 1'b1; noc_din = 32'hF100_0000 + i;
      tick();
    end
    host_wr_en = 1'b0; noc_vin = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("t7_vout",  {31'd0, noc_vout},   32'd0);
    chk("t7_empty", {31'd0, host_empty}, 32'd1);
    chk("t7_rx",    {16'd0, rx_count},   32'd0);
    #10 rst = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
